// File: rtl/tsu_pkg.sv
// Shared types and constants for the PTP timestamp write arbiter.
// Fixed-priority arbitration is selected by defining TSU_ARB_PRIO_EN.
package tsu_pkg;

    localparam int TSU_REC_W  = 128;
    localparam int SRC_ID_LSB = 120;
    localparam int TS_LSB     = 32;
    localparam int INFO_LSB   = 0;
    localparam int OVF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2
    } tsu_state_e;

    // Source id goes in the top byte, the next byte is forced to zero.
    function automatic logic [TSU_REC_W-1:0] tsu_tag(input logic [7:0]           id,
                                                     input logic [TSU_REC_W-1:0] rec);
        return {id, 8'h00, rec[SRC_ID_LSB-9:INFO_LSB]};
    endfunction

endpackage

// File: rtl/tsu_hold_fifo.sv
// Two-entry record buffer in front of the arbiter; flags a drop when a push
// arrives while full and nothing is popped in the same cycle.
module tsu_hold_fifo
    import tsu_pkg::*;
(
    input  logic                 gmii_clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [TSU_REC_W-1:0] din,
    output logic [TSU_REC_W-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic                 drop
);

    logic [TSU_REC_W-1:0] mem_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic                 push_ok;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge gmii_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tsu_wr_arbiter.sv
// Shares the timestamp dcfifo write port among NUM_REQ sources, pacing writes
// against q_wrusedw. Define TSU_ARB_PRIO_EN for fixed priority instead of round-robin.
module tsu_wr_arbiter
    import tsu_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int USEDW_W     = 4,
    parameter int FULL_THRESH = 15
) (
    input  logic                           gmii_clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [TSU_REC_W*NUM_REQ-1:0]   req_data,
    input  logic [USEDW_W-1:0]             q_wrusedw,
    output logic                           q_wr_en,
    output logic [TSU_REC_W-1:0]           q_wr_data,
    output logic [1:0]                     grant_id,
    input  logic                           ovf_clr,
    output logic [OVF_CNT_W*NUM_REQ-1:0]   ovf_cnt,
    output logic                           busy
);

    tsu_state_e           state_q;
    logic                 q_wr_en_q;
    logic [TSU_REC_W-1:0] q_wr_data_q;
    logic [1:0]           grant_id_q;
    logic [1:0]           rr_q;
    logic [1:0]           rr_d;

    logic [NUM_REQ-1:0]   fifo_full;
    logic [NUM_REQ-1:0]   fifo_empty;
    logic [NUM_REQ-1:0]   fifo_drop;
    logic [NUM_REQ-1:0]   fifo_pop;
    logic [TSU_REC_W-1:0] fifo_head [NUM_REQ];

    logic                 sel_valid;
    logic [1:0]           sel_id;
    logic [2:0]           scan_idx;
    logic [TSU_REC_W-1:0] sel_data;
    logic                 below_thresh;
    logic                 grant_go;
    logic                 unused_bits;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
            logic [OVF_CNT_W-1:0] cnt_q;

            tsu_hold_fifo u_fifo (
                .gmii_clk (gmii_clk),
                .rst      (rst),
                .push     (req_valid[gi]),
                .pop      (fifo_pop[gi]),
                .din      (req_data[TSU_REC_W*gi +: TSU_REC_W]),
                .dout     (fifo_head[gi]),
                .full     (fifo_full[gi]),
                .empty    (fifo_empty[gi]),
                .drop     (fifo_drop[gi])
            );

            assign fifo_pop[gi] = grant_go && (sel_id == 2'(gi));

            // A clear that lands on a drop still counts that drop.
            always_ff @(posedge gmii_clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (ovf_clr) begin
                    cnt_q <= fifo_drop[gi] ? OVF_CNT_W'(1) : '0;
                end else if (fifo_drop[gi] && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + OVF_CNT_W'(1);
                end
            end

            assign ovf_cnt[OVF_CNT_W*gi +: OVF_CNT_W] = cnt_q;
        end
    endgenerate

    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        scan_idx  = '0;
`ifdef TSU_ARB_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (!fifo_empty[k]) begin
                sel_valid = 1'b1;
                sel_id    = 2'(k);
            end
        end
`else
        // Scan downward from the farthest offset so the nearest hit to rr_q wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = 3'(rr_q) + 3'(k);
            if (scan_idx >= 3'(NUM_REQ)) begin
                scan_idx = scan_idx - 3'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((scan_idx == 3'(j)) && !fifo_empty[j]) begin
                    sel_valid = 1'b1;
                    sel_id    = 2'(j);
                end
            end
        end
`endif
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_id == 2'(k)) begin
                sel_data = fifo_head[k];
            end
        end
    end

    assign unused_bits  = ^sel_data[TSU_REC_W-1:SRC_ID_LSB-8] ^ fifo_full[0] ^ (^rr_q);
    assign below_thresh = (32'(q_wrusedw) < 32'(FULL_THRESH));
    assign grant_go     = (state_q == IDLE) && sel_valid && below_thresh;
    assign rr_d         = (grant_id_q == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id_q + 2'd1;

    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_wr_en_q   <= 1'b0;
            q_wr_data_q <= '0;
            grant_id_q  <= '0;
            rr_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    q_wr_en_q <= 1'b0;
                    if (grant_go) begin
                        state_q     <= WRITE;
                        q_wr_en_q   <= 1'b1;
                        q_wr_data_q <= tsu_tag({6'd0, sel_id}, sel_data);
                        grant_id_q  <= sel_id;
                    end
                end
                WRITE: begin
                    q_wr_en_q <= 1'b0;
                    rr_q      <= rr_d;
                    state_q   <= SETTLE;
                end
                // Gap cycle lets q_wrusedw catch up with the write just issued.
                SETTLE: begin
                    q_wr_en_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    q_wr_en_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign q_wr_en   = q_wr_en_q;
    assign q_wr_data = q_wr_data_q;
    assign grant_id  = grant_id_q;
    assign busy      = (~&fifo_empty) | (state_q != IDLE);

endmodule
